fnd_source_arbiter: RTL
=======================

FND_SOURCE_ARBITER -- requirements
Module: fnd_source_arbiter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter HOLD_MS, default 3000, the UART display-override hold time in ms (>=1).
REQ-003 SHALL have parameter PAGE_MS, default 2000, the auto page-rotation period in ms (>=1).
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wt_data  in  32  watch time {hour,min,sec,msec}, always valid, default source.
REQ-007 SHALL have port sw_valid  in  1  stopwatch requests display (level).
REQ-008 SHALL have port sw_data  in  32  stopwatch time, same packing.
REQ-009 SHALL have port uart_req  in  1  UART display request (single-cycle pulse).
REQ-010 SHALL have port uart_data  in  32  UART-supplied time, sampled when uart_req=1.
REQ-011 SHALL have port uart_ack  out  1  one-cycle acknowledge of an accepted uart_req.
REQ-012 SHALL have port user_sel  in  1  manual page: 1 hour:min, 0 sec:msec.
REQ-013 SHALL have port auto_page  in  1  enable automatic page rotation.
REQ-014 SHALL have port edit_mode  in  1  watch edit active (blink request).
REQ-015 SHALL have port fnd_in_data  out  32  registered data to display controller.
REQ-016 SHALL have port sel_display  out  1  registered page select to display controller.
REQ-017 SHALL have port mode  out  1  registered blink enable to display controller.
REQ-018 SHALL have port src  out  2  current owner: 00 watch, 01 stopwatch, 10 UART.

Function
REQ-019 SHALL implement FSM states S_WATCH, S_SW, S_UART; src encodes the state; 11 never driven.
REQ-020 SHALL use fixed priority UART > stopwatch > watch; state changes take effect on the clock edge after the causing input.
REQ-021 S_WATCH/S_SW: uart_req=1 SHALL go to S_UART, latch uart_data, pulse uart_ack next cycle, clear hold timer and ms prescaler.
REQ-022 S_WATCH: sw_valid=1 (no uart_req) SHALL go to S_SW; S_SW: sw_valid=0 SHALL go to S_WATCH.
REQ-023 S_UART: uart_req=1 SHALL re-latch uart_data, re-ack and restart the hold from zero.
REQ-024 S_UART: hold SHALL expire exactly HOLD_MS*CLK_HZ/1000 cycles after the last accepted request; exit to S_SW if sw_valid=1, else S_WATCH; simultaneous expiry and uart_req SHALL restart the hold (stay).
REQ-025 fnd_in_data SHALL register wt_data, sw_data or latched UART data per the next state (one-cycle latency from input to output).
REQ-026 ms prescaler SHALL count 0..CLK_HZ/1000-1 and emit a 1-cycle ms tick at the terminal count, free-running except as cleared by REQ-021/023.
REQ-027 Page toggle SHALL invert every PAGE_MS ms ticks while auto_page=1; held at 1 with its counter cleared while auto_page=0.
REQ-028 sel_display SHALL equal the page toggle when auto_page=1, else user_sel; in S_SW it SHALL equal user_sel regardless.
REQ-029 mode SHALL be 1 only when next state is S_WATCH and edit_mode=1.
REQ-030 All counters SHALL wrap to 0 at terminal count and never overflow their width ($clog2 sized).

Reset
REQ-031 On rst: state S_WATCH, src=00, fnd_in_data=0, sel_display=1, mode=0, uart_ack=0, latched UART data 0, all counters 0, page toggle 1.
REQ-032 rst asserted mid-hold SHALL abandon the override; after release the block resumes from S_WATCH with no ack.

Configuration
REQ-033 Macro FND_ARB_AUTO_PAGE_EN defined: auto rotation per REQ-027/028 compiled in.
REQ-034 FND_ARB_AUTO_PAGE_EN undefined: page counter/toggle absent, auto_page ignored, sel_display always follows user_sel; all else unchanged.

Verification (CLK_HZ=10_000, HOLD_MS=3, PAGE_MS=2: 10 cycles/ms)
REQ-035 Release rst, wt_data=0x0C1E2D05 -> src=00, fnd_in_data=0x0C1E2D05 one cycle later, mode=0.
REQ-036 sw_valid=1 with sw_data=0x00010203 -> src=01 next edge, fnd_in_data=0x00010203; sw_valid=0 -> src=00 next edge.
REQ-037 uart_req pulse, uart_data=0x173B3B00 in S_SW -> uart_ack=1 one cycle, src=10, data held exactly 30 cycles, then src=01 (sw_valid=1).
REQ-038 Second uart_req 20 cycles into hold -> re-ack, new data, src=10 for 30 further cycles.
REQ-039 auto_page=1 in S_WATCH -> sel_display toggles every 20 cycles; edit_mode=1 -> mode=1, and mode=0 while src=10.
REQ-040 rst pulse 10 cycles into UART hold -> all outputs reset values immediately; src=00 after release; macro undefined build: sel_display tracks user_sel with auto_page=1.

Source files
------------

// File: rtl/fnd_source_arbiter.sv
// Display source arbiter: UART override > stopwatch > watch, with registered display outputs.
// Define FND_ARB_AUTO_PAGE_EN to compile in automatic page rotation.
module fnd_source_arbiter #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned HOLD_MS = 3000,
  parameter int unsigned PAGE_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wt_data,
  input  logic        sw_valid,
  input  logic [31:0] sw_data,
  input  logic        uart_req,
  input  logic [31:0] uart_data,
  output logic        uart_ack,
  input  logic        user_sel,
  input  logic        auto_page,
  input  logic        edit_mode,
  output logic [31:0] fnd_in_data,
  output logic        sel_display,
  output logic        mode,
  output logic [1:0]  src
);

  localparam int unsigned MS_CYC = CLK_HZ / 1000;
  localparam longint unsigned HOLD_CYC = (64'(HOLD_MS) * 64'(CLK_HZ)) / 64'd1000;
  localparam int unsigned PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    S_WATCH = 2'b00,
    S_SW    = 2'b01,
    S_UART  = 2'b10
  } state_t;

  state_t             state, state_next;
  logic [PRE_W-1:0]   pre;
  logic [HOLD_W-1:0]  hold;
  logic [31:0]        uart_q;
  logic [31:0]        data_next;
  logic               tick, expire, sel_next;

`ifdef FND_ARB_AUTO_PAGE_EN
  localparam int unsigned PAGE_W = (PAGE_MS > 1) ? $clog2(PAGE_MS) : 1;
  logic [PAGE_W-1:0]  page_cnt, page_cnt_next;
  logic               page, page_next;
`endif

  always_comb begin
    tick   = (pre == PRE_W'(MS_CYC - 1));
    expire = (state == S_UART) && (hold == HOLD_W'(HOLD_CYC - 1));

    state_next = state;
    case (state)
      S_WATCH: if (uart_req) state_next = S_UART;
               else if (sw_valid) state_next = S_SW;
      S_SW:    if (uart_req) state_next = S_UART;
               else if (!sw_valid) state_next = S_WATCH;
      S_UART:  if (uart_req) state_next = S_UART;
               else if (expire) state_next = sw_valid ? S_SW : S_WATCH;
      default: state_next = S_WATCH;
    endcase

    // An accepting cycle shows the incoming UART word, not the stale latch.
    case (state_next)
      S_SW:    data_next = sw_data;
      S_UART:  data_next = uart_req ? uart_data : uart_q;
      default: data_next = wt_data;
    endcase

`ifdef FND_ARB_AUTO_PAGE_EN
    page_next     = page;
    page_cnt_next = page_cnt;
    if (!auto_page) begin
      page_next     = 1'b1;
      page_cnt_next = '0;
    end else if (tick) begin
      if (page_cnt == PAGE_W'(PAGE_MS - 1)) begin
        page_cnt_next = '0;
        page_next     = ~page;
      end else begin
        page_cnt_next = page_cnt + PAGE_W'(1);
      end
    end
    sel_next = (!auto_page || state_next == S_SW) ? user_sel : page_next;
`else
    // Rotation compiled out: auto_page and tick are intentionally inert here.
    sel_next = user_sel | (1'b0 & auto_page & tick);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_WATCH;
      pre         <= '0;
      hold        <= '0;
      uart_q      <= '0;
      fnd_in_data <= '0;
      sel_display <= 1'b1;
      mode        <= 1'b0;
      uart_ack    <= 1'b0;
`ifdef FND_ARB_AUTO_PAGE_EN
      page        <= 1'b1;
      page_cnt    <= '0;
`endif
    end else begin
      state <= state_next;
      if (uart_req) begin
        pre    <= '0;
        hold   <= '0;
        uart_q <= uart_data;
      end else begin
        pre  <= tick ? '0 : pre + PRE_W'(1);
        hold <= (state == S_UART && !expire) ? hold + HOLD_W'(1) : '0;
      end
      fnd_in_data <= data_next;
      sel_display <= sel_next;
      mode        <= (state_next == S_WATCH) && edit_mode;
      uart_ack    <= uart_req;
`ifdef FND_ARB_AUTO_PAGE_EN
      page        <= page_next;
      page_cnt    <= page_cnt_next;
`endif
    end
  end

  assign src = state;

endmodule
